// File: rtl/comp_pkg.sv
// Shared definitions for the complex multiply/accumulate datapath.
package comp_pkg;

    localparam int PROD_W = 17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Wide enough to hold the value LEN itself, not just LEN-1.
    function automatic int cnt_width(input int len);
        return $clog2(len) + 1;
    endfunction

endpackage

// File: rtl/comp_acc_lane.sv
// One signed accumulator lane: sign-extension, load/add select, optional
// saturation (enabled by COMP_ACC_SAT_EN, otherwise the add wraps).
module comp_acc_lane
    import comp_pkg::*;
#(
    parameter int ACC_W = 21
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic                     load,
    input  logic signed [PROD_W-1:0] p,
    output logic signed [ACC_W-1:0]  acc_nxt
);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] add_res;

    assign ext = p;
    assign sum = acc + ext;

`ifdef COMP_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic ovf_pos;
    logic ovf_neg;

    // Overflow only when both operands share a sign the result lost.
    assign ovf_pos = !acc[ACC_W-1] && !ext[ACC_W-1] &&  sum[ACC_W-1];
    assign ovf_neg =  acc[ACC_W-1] &&  ext[ACC_W-1] && !sum[ACC_W-1];
    assign add_res = ovf_pos ? SAT_MAX : (ovf_neg ? SAT_MIN : sum);
`else
    assign add_res = sum;
`endif

    assign acc_nxt = load ? ext : add_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_nxt;
        end
    end

endmodule

// File: rtl/comp_acc.sv
// Complex block accumulator: sums LEN products per block and holds the result
// until acknowledged. Saturating lanes when COMP_ACC_SAT_EN is defined.
module comp_acc
    import comp_pkg::*;
#(
    parameter int LEN   = 16,
    parameter int ACC_W = 21
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic signed [PROD_W-1:0] p_r,
    input  logic signed [PROD_W-1:0] p_i,
    input  logic                     p_valid,
    output logic                     p_ready,
    output logic signed [ACC_W-1:0]  o_r,
    output logic signed [ACC_W-1:0]  o_i,
    output logic                     o_valid,
    input  logic                     o_ready
);

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // p_ready is decoded from state only, o_valid is a register.
    localparam int CNT_W = cnt_width(LEN);
    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt, cnt_inc;
    logic                    o_valid_nxt;
    logic                    capture;
    logic                    lane_en;
    logic                    lane_load;
    logic signed [ACC_W-1:0] nxt_r, nxt_i;

    assign p_ready = (state != ST_HOLD);
    assign cnt_inc = cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            o_valid <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            o_valid <= o_valid_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        o_valid_nxt = o_valid;
        capture     = 1'b0;
        lane_en     = 1'b0;
        lane_load   = 1'b0;
        if (i_clr) begin
            state_nxt   = ST_IDLE;
            cnt_nxt     = '0;
            o_valid_nxt = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (p_valid) begin
                        lane_en   = 1'b1;
                        lane_load = 1'b1;
                        cnt_nxt   = CNT_W'(1);
                        if (LEN == 1) begin
                            capture     = 1'b1;
                            o_valid_nxt = 1'b1;
                            state_nxt   = ST_HOLD;
                        end else begin
                            state_nxt = ST_ACC;
                        end
                    end
                end
                ST_ACC: begin
                    if (p_valid) begin
                        lane_en = 1'b1;
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == LEN_C) begin
                            capture     = 1'b1;
                            o_valid_nxt = 1'b1;
                            state_nxt   = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (o_ready) begin
                        o_valid_nxt = 1'b0;
                        state_nxt   = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    comp_acc_lane #(.ACC_W(ACC_W)) u_lane_r (
        .clk     (clk),
        .rst     (rst),
        .clr     (i_clr),
        .en      (lane_en),
        .load    (lane_load),
        .p       (p_r),
        .acc_nxt (nxt_r)
    );

    comp_acc_lane #(.ACC_W(ACC_W)) u_lane_i (
        .clk     (clk),
        .rst     (rst),
        .clr     (i_clr),
        .en      (lane_en),
        .load    (lane_load),
        .p       (p_i),
        .acc_nxt (nxt_i)
    );

    // Result registers keep their value after the output transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_r <= '0;
            o_i <= '0;
        end else if (i_clr) begin
            o_r <= '0;
            o_i <= '0;
        end else if (capture) begin
            o_r <= nxt_r;
            o_i <= nxt_i;
        end
    end

endmodule

// File: tb/tb_comp_acc.sv
// Bench for comp_acc: three instances (LEN=4/W=21, LEN=1/W=21, LEN=4/W=18)
// checked every cycle against a block-sum model; COMP_ACC_SAT_EN aware.
module tb_comp_acc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic               clr_a  [3];
    logic               pv_a   [3];
    logic signed [16:0] pr_a   [3];
    logic signed [16:0] pi_a   [3];
    logic               ordy_a [3];
    logic               prdy_a [3];
    logic               ov_a   [3];

    logic signed [20:0] o_r0, o_i0, o_r1, o_i1;
    logic signed [17:0] o_r2, o_i2;

    int vectors    = 0;
    int miscompares = 0;

    comp_acc #(.LEN(4), .ACC_W(21)) dut0 (
        .clk(clk), .rst(rst), .i_clr(clr_a[0]), .p_r(pr_a[0]), .p_i(pi_a[0]),
        .p_valid(pv_a[0]), .p_ready(prdy_a[0]), .o_r(o_r0), .o_i(o_i0),
        .o_valid(ov_a[0]), .o_ready(ordy_a[0])
    );
    comp_acc #(.LEN(1), .ACC_W(21)) dut1 (
        .clk(clk), .rst(rst), .i_clr(clr_a[1]), .p_r(pr_a[1]), .p_i(pi_a[1]),
        .p_valid(pv_a[1]), .p_ready(prdy_a[1]), .o_r(o_r1), .o_i(o_i1),
        .o_valid(ov_a[1]), .o_ready(ordy_a[1])
    );
    comp_acc #(.LEN(4), .ACC_W(18)) dut2 (
        .clk(clk), .rst(rst), .i_clr(clr_a[2]), .p_r(pr_a[2]), .p_i(pi_a[2]),
        .p_valid(pv_a[2]), .p_ready(prdy_a[2]), .o_r(o_r2), .o_i(o_i2),
        .o_valid(ov_a[2]), .o_ready(ordy_a[2])
    );

    // ---------------- behavioural model ----------------
    int     m_len [3] = '{4, 1, 4};
    int     m_w   [3] = '{21, 21, 18};
    bit     m_hold  [3] = '{0, 0, 0};
    int     m_cnt   [3] = '{0, 0, 0};
    longint m_acc_r [3] = '{0, 0, 0};
    longint m_acc_i [3] = '{0, 0, 0};
    longint m_out_r [3] = '{0, 0, 0};
    longint m_out_i [3] = '{0, 0, 0};

    function automatic longint fit(input longint s, input int w);
        longint lim;
        logic [63:0] u;
        lim = longint'(1) <<< (w - 1);
`ifdef COMP_ACC_SAT_EN
        if (s > lim - 1) return lim - 1;
        if (s < -lim)    return -lim;
        return s;
`else
        u = s;
        u = u & ((64'd1 << w) - 64'd1);
        if (u >= (64'd1 << (w - 1))) return longint'(u) - (lim * 2);
        return longint'(u);
`endif
    endfunction

    task automatic model_reset(input int k);
        m_hold[k] = 0; m_cnt[k] = 0;
        m_acc_r[k] = 0; m_acc_i[k] = 0;
        m_out_r[k] = 0; m_out_i[k] = 0;
    endtask

    task automatic model_step(input int k);
        if (clr_a[k]) begin
            model_reset(k);
        end else if (m_hold[k]) begin
            if (ordy_a[k]) m_hold[k] = 0;
        end else if (pv_a[k]) begin
            if (m_cnt[k] == 0) begin
                m_acc_r[k] = pr_a[k];
                m_acc_i[k] = pi_a[k];
            end else begin
                m_acc_r[k] = fit(m_acc_r[k] + longint'(pr_a[k]), m_w[k]);
                m_acc_i[k] = fit(m_acc_i[k] + longint'(pi_a[k]), m_w[k]);
            end
            m_cnt[k]++;
            if (m_cnt[k] == m_len[k]) begin
                m_out_r[k] = m_acc_r[k];
                m_out_i[k] = m_acc_i[k];
                m_hold[k]  = 1;
                m_cnt[k]   = 0;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) model_reset(k);
            else     model_step(k);
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic signed [63:0] act_r(input int k);
        if (k == 0) return o_r0;
        if (k == 1) return o_r1;
        return o_r2;
    endfunction

    function automatic logic signed [63:0] act_i(input int k);
        if (k == 0) return o_i0;
        if (k == 1) return o_i1;
        return o_i2;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("p_ready%0d", k), {63'd0, prdy_a[k]}, {63'd0, !m_hold[k]});
            chk($sformatf("o_valid%0d", k), {63'd0, ov_a[k]},   {63'd0, m_hold[k]});
            chk($sformatf("o_r%0d", k), act_r(k), m_out_r[k]);
            chk($sformatf("o_i%0d", k), act_i(k), m_out_i[k]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input int k, input bit v, input int r, input int i,
                         input bit ordy, input bit clr);
        pv_a[k]   = v;
        pr_a[k]   = 17'(r);
        pi_a[k]   = 17'(i);
        ordy_a[k] = ordy;
        clr_a[k]  = clr;
        @(negedge clk);
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            pv_a[k] = 0; pr_a[k] = '0; pi_a[k] = '0; ordy_a[k] = 0; clr_a[k] = 0;
        end
    endtask

    task automatic release_out(input int k);
        drive(k, 0, 0, 0, 1, 0);
        drive(k, 0, 0, 0, 0, 0);
    endtask

    int exp_ovf_r, exp_ovf_i;

    initial begin
        idle_all();
        @(negedge clk);
        chk("rst_p_ready", {63'd0, prdy_a[0]}, 64'sd1);
        chk("rst_o_valid", {63'd0, ov_a[0]}, 64'sd0);
        chk("rst_o_r", act_r(0), 64'sd0);
        @(negedge clk);
        rst = 1'b0;

        // basic block
        for (int n = 0; n < 4; n++) drive(0, 1, 100, -50, 0, 0);
        chk("basic_valid", {63'd0, ov_a[0]}, 64'sd1);
        chk("basic_r", act_r(0), 64'sd400);
        chk("basic_i", act_i(0), -64'sd200);
        chk("model_basic_r", m_out_r[0], 64'sd400);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("basic_hold_ready", {63'd0, prdy_a[0]}, 64'sd0);
        release_out(0);

        // gapped block, then backpressure with p_valid held high
        drive(0, 1, 1, 2, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 1, 3, 4, 0, 0);
        for (int n = 0; n < 3; n++) drive(0, 0, 0, 0, 0, 0);
        drive(0, 1, -5, -6, 0, 0);
        drive(0, 1, 7, 8, 0, 0);
        chk("gap_r", act_r(0), 64'sd6);
        chk("gap_i", act_i(0), 64'sd8);
        chk("model_gap_i", m_out_i[0], 64'sd8);
        for (int n = 0; n < 10; n++) drive(0, 1, 500 + n, 600 + n, 0, 0);
        chk("bp_r", act_r(0), 64'sd6);
        drive(0, 1, 999, 999, 1, 0);
        for (int n = 0; n < 4; n++) drive(0, 1, 2, -3, 0, 0);
        chk("fresh_r", act_r(0), 64'sd8);
        chk("fresh_i", act_i(0), -64'sd12);
        release_out(0);

        // clear mid-block
        drive(0, 1, 99, 99, 0, 0);
        drive(0, 1, 99, 99, 0, 0);
        drive(0, 1, 55, 55, 0, 1);
        for (int n = 0; n < 4; n++) drive(0, 1, 10, 10, 0, 0);
        chk("clr_r", act_r(0), 64'sd40);
        chk("clr_i", act_i(0), 64'sd40);

        // asynchronous reset while holding a result
        drive(0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_o_valid", {63'd0, ov_a[0]}, 64'sd0);
        chk("arst_o_r", act_r(0), 64'sd0);
        chk("arst_o_i", act_i(0), 64'sd0);
        @(negedge clk);
        rst = 1'b0;

        // LEN=1
        drive(1, 1, -7, 9, 0, 0);
        chk("len1_valid", {63'd0, ov_a[1]}, 64'sd1);
        chk("len1_r", act_r(1), -64'sd7);
        chk("len1_i", act_i(1), 64'sd9);
        for (int n = 0; n < 6; n++) drive(1, 1, -7, 9, 1, 0);
        drive(1, 0, 0, 0, 1, 0);

        // overflow, ACC_W=18
`ifdef COMP_ACC_SAT_EN
        exp_ovf_r = 131071; exp_ovf_i = -131072;
`else
        exp_ovf_r = -4; exp_ovf_i = 0;
`endif
        for (int n = 0; n < 4; n++) drive(2, 1, 65535, -65536, 0, 0);
        chk("ovf_r", act_r(2), 64'(exp_ovf_r));
        chk("ovf_i", act_i(2), 64'(exp_ovf_i));
        chk("model_ovf_r", m_out_r[2], 64'(exp_ovf_r));
        release_out(2);

        // randomized traffic on all instances
        for (int n = 0; n < 2000; n++) begin
            for (int k = 0; k < 3; k++) begin
                pv_a[k]   = ($urandom_range(0, 3) != 0);
                pr_a[k]   = 17'($urandom_range(0, 131071));
                pi_a[k]   = 17'($urandom_range(0, 131071));
                ordy_a[k] = ($urandom_range(0, 2) == 0);
                clr_a[k]  = ($urandom_range(0, 39) == 0);
            end
            @(negedge clk);
        end
        idle_all();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
